// File: rtl/input_port_if.sv
// CPU-facing port bundle: external pins and control byte in, captured data and interrupt out.
// Pure wiring, no latency.
// No backpressure; the bus is level-based and sampled every cycle.
interface input_port_if;
    logic [7:0] pins;
    logic [7:0] ctrl;
    logic [7:0] data;
    logic       irq;

    // Environment / CPU side: drives pins and the command byte, reads results.
    modport master (
        output pins,
        output ctrl,
        input  data,
        input  irq
    );

    // Peripheral side.
    modport slave (
        input  pins,
        input  ctrl,
        output data,
        output irq
    );
endinterface

// File: rtl/input_port.sv
// Debounced 8-pin input peripheral: captures qualifying pin changes and raises irq until acked.
// Latency: pin change to db is 1+DEBOUNCE_CYCLES edges, to data/irq 2+DEBOUNCE_CYCLES edges.
// No backpressure; events arriving while an interrupt is pending are dropped (db keeps updating).
module input_port #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input_port_if.slave  port
);

    localparam logic [7:0] DB_LIM = 8'(DEBOUNCE_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] db;
    logic [7:0] cand;
    logic [7:0] cnt;
    logic       ack_q;
    logic       evt_q;
    logic [7:0] evt_dat;
    logic [1:0] state;
    logic [7:0] data_r;
    logic       irq_r;

    logic       en;
    logic       ack;
    logic [1:0] mode;
    logic [7:0] cnt_nxt;
    logic       accept;
    logic       qualify;

    // Bits 5:2 of the command byte carry no function here.
    logic unused_ctrl;
    assign unused_ctrl = ^port.ctrl[5:2];

    assign en   = port.ctrl[7];
    assign mode = port.ctrl[1:0];
    assign ack  = port.ctrl[6] & ~ack_q;

    // Count the current cycle would reach; a fresh candidate starts at 1.
    assign cnt_nxt = (s2 != cand) ? 8'd1 : cnt + 8'd1;
    // Accept when the differing value has been stable for DEBOUNCE_CYCLES samples.
    assign accept  = (s2 != db) && (cnt_nxt == DB_LIM);

    // Event qualification against the accepted value before the update.
    always_comb begin
        qualify = 1'b0;
        case (mode)
            2'b00:   qualify = (s2 != db);
            2'b01:   qualify = |(s2 & ~db);
            2'b10:   qualify = |(~s2 & db);
            default: qualify = 1'b0;
        endcase
    end

    // Two-flop synchronizer and previous-cycle ack bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 8'h00;
            s2    <= 8'h00;
            ack_q <= 1'b0;
        end else begin
            s1    <= port.pins;
            s2    <= s1;
            ack_q <= port.ctrl[6];
        end
    end

    // Whole-word debounce; also registers the accept event for the control FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db      <= 8'h00;
            cand    <= 8'h00;
            cnt     <= 8'h00;
            evt_q   <= 1'b0;
            evt_dat <= 8'h00;
        end else begin
            evt_q <= 1'b0;
            if (s2 == db) begin
                cnt <= 8'h00;
            end else if (accept) begin
                db      <= s2;
                cand    <= s2;
                cnt     <= 8'h00;
                evt_q   <= qualify;
                evt_dat <= s2;
            end else begin
                cand <= s2;
                cnt  <= cnt_nxt;
            end
        end
    end

    // Control FSM: disable overrides everything; a new event beats a simultaneous ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            data_r <= 8'h00;
            irq_r  <= 1'b0;
        end else if (!en) begin
            state  <= IDLE;
            data_r <= db;
            irq_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= ARMED;
                    data_r <= db;
                    irq_r  <= 1'b0;
                end
                ARMED: begin
                    if (evt_q) begin
                        state  <= PENDING;
                        data_r <= evt_dat;
                        irq_r  <= 1'b1;
                    end else if (mode == 2'b11) begin
                        data_r <= db;
                    end
                end
                PENDING: begin
                    if (ack && evt_q) begin
                        data_r <= evt_dat;
                        irq_r  <= 1'b1;
                    end else if (ack) begin
                        state <= ARMED;
                        irq_r <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq_r <= 1'b0;
                end
            endcase
        end
    end

    assign port.data = data_r;
    assign port.irq  = irq_r;

endmodule

// File: tb/tb_input_port.sv
// Scoreboard bench for input_port: stimulus queues expected data/irq per clock edge, monitor compares.
// Expected values are hand-computed from the pin-to-output latency (db at edge 1+D, outputs at 2+D).
// Outputs are sampled 2 time units after each rising edge.
module tb_input_port;

    localparam int D = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   base;
    int   checks;
    int   failures;

    input_port_if bus ();

    input_port #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       i;
        logic       cdb;
        logic [7:0] db;
        string      name;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the reference point: the next rising edge is edge 0.
    task automatic mark();
        base = cyc;
    endtask

    // Expect output values after edge m relative to the last mark.
    task automatic expect_at(input int m, input logic [7:0] d, input logic i, input string name);
        exp_t e;
        e.cyc = base + 1 + m; e.d = d; e.i = i; e.cdb = 1'b0; e.db = 8'h00; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_db(input int m, input logic [7:0] d, input logic i,
                             input logic [7:0] dbv, input string name);
        exp_t e;
        e.cyc = base + 1 + m; e.d = d; e.i = i; e.cdb = 1'b1; e.db = dbv; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: after each rising edge, compare every expectation due on this edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
                end else begin
                    checks++;
                    if (bus.data !== e.d) begin
                        failures++;
                        $display("FAIL %s data: got %02h want %02h (cycle %0d)", e.name, bus.data, e.d, cyc);
                    end
                    checks++;
                    if (bus.irq !== e.i) begin
                        failures++;
                        $display("FAIL %s irq: got %0b want %0b (cycle %0d)", e.name, bus.irq, e.i, cyc);
                    end
                    if (e.cdb) begin
                        checks++;
                        if (dut.db !== e.db) begin
                            failures++;
                            $display("FAIL %s db: got %02h want %02h (cycle %0d)", e.name, dut.db, e.db, cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        cyc      = 0;
        base     = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bus.pins = 8'h00;
        bus.ctrl = 8'h00;

        // Reset held while pins toggle: outputs stay cleared.
        wait_neg(1);
        mark();
        expect_at(0, 8'h00, 1'b0, "rst_hold");
        for (int k = 0; k < 4; k++) begin
            bus.pins = (k % 2 == 0) ? 8'hFF : 8'hA5;
            wait_neg(1);
        end
        bus.pins = 8'h00;
        wait_neg(1);
        reset = 1'b1;
        mark();
        for (int k = 0; k < 20; k++) expect_at(k, 8'h00, 1'b0, "idle_quiet");
        wait_neg(21);

        // Basic capture in mode 00, then ack.
        bus.ctrl = 8'h80;
        wait_neg(2);
        mark();
        bus.pins = 8'h05;
        expect_at(D + 1, 8'h00, 1'b0, "cap_pre");
        expect_at(D + 2, 8'h05, 1'b1, "cap_irq");
        wait_neg(D + 3);
        mark();
        bus.ctrl = 8'hC0;
        expect_at(0, 8'h05, 1'b0, "cap_ack");
        wait_neg(1);
        bus.ctrl = 8'h80;
        wait_neg(1);

        // Return pins to 0 through IDLE (data tracks db).
        bus.ctrl = 8'h00;
        bus.pins = 8'h00;
        wait_neg(10);
        mark();
        expect_at(0, 8'h00, 1'b0, "idle_track");
        bus.ctrl = 8'h80;
        wait_neg(2);

        // Glitch rejection: 3-cycle pulse is ignored.
        mark();
        bus.pins = 8'h01;
        for (int k = 2; k <= 12; k += 2) expect_at(k, 8'h00, 1'b0, "glitch_3");
        wait_neg(3);
        bus.pins = 8'h00;
        wait_neg(12);

        // 4-cycle pulse is accepted; the following return to 0 is dropped while pending.
        mark();
        bus.pins = 8'h01;
        expect_at(D + 1, 8'h00, 1'b0, "pulse4_pre");
        expect_at(D + 2, 8'h01, 1'b1, "pulse4_irq");
        expect_at(11, 8'h01, 1'b1, "pulse4_drop");
        wait_neg(4);
        bus.pins = 8'h00;
        wait_neg(9);
        mark();
        bus.ctrl = 8'hC0;
        expect_at(0, 8'h01, 1'b0, "pulse4_ack");
        wait_neg(1);
        bus.ctrl = 8'h80;
        wait_neg(1);

        // Mode 01: set pins to 1 via IDLE, then a fall does not interrupt, a rise does.
        bus.ctrl = 8'h00;
        bus.pins = 8'h01;
        wait_neg(10);
        bus.ctrl = 8'h81;
        wait_neg(2);
        mark();
        bus.pins = 8'h00;
        expect_at(D + 2, 8'h01, 1'b0, "rise_fall_none");
        expect_at(D + 4, 8'h01, 1'b0, "rise_fall_none2");
        wait_neg(10);
        mark();
        bus.pins = 8'h02;
        expect_at(D + 1, 8'h01, 1'b0, "rise_pre");
        expect_at(D + 2, 8'h02, 1'b1, "rise_irq");
        wait_neg(D + 3);
        mark();
        bus.ctrl = 8'hC2;
        expect_at(0, 8'h02, 1'b0, "rise_ack");
        wait_neg(1);
        bus.ctrl = 8'h82;
        wait_neg(1);

        // Mode 10: a fall interrupts.
        mark();
        bus.pins = 8'h00;
        expect_at(D + 1, 8'h02, 1'b0, "fall_pre");
        expect_at(D + 2, 8'h00, 1'b1, "fall_irq");
        wait_neg(D + 3);
        mark();
        bus.ctrl = 8'hC0;
        expect_at(0, 8'h00, 1'b0, "fall_ack");
        wait_neg(1);
        bus.ctrl = 8'h80;
        wait_neg(1);

        // Pending: capture 0x05, then 0x07 updates db only.
        mark();
        bus.pins = 8'h05;
        expect_at(D + 2, 8'h05, 1'b1, "pend_irq");
        wait_neg(D + 3);
        mark();
        bus.pins = 8'h07;
        expect_db(D + 1, 8'h05, 1'b1, 8'h07, "pend_db");
        expect_at(D + 3, 8'h05, 1'b1, "pend_hold");
        wait_neg(D + 4);

        // Ack on the same edge as a qualifying event for 0x0F: new event wins.
        mark();
        bus.pins = 8'h0F;
        expect_db(D + 1, 8'h05, 1'b1, 8'h0F, "simul_pre");
        expect_at(D + 2, 8'h0F, 1'b1, "simul_irq");
        expect_at(D + 4, 8'h0F, 1'b1, "simul_stay");
        wait_neg(D + 2);
        bus.ctrl = 8'hC0;
        wait_neg(1);
        bus.ctrl = 8'h80;
        wait_neg(3);

        // Disable while pending: irq drops next edge, data tracks db.
        mark();
        bus.ctrl = 8'h00;
        bus.pins = 8'h11;
        expect_at(0, 8'h0F, 1'b0, "dis_irq");
        expect_at(D + 1, 8'h0F, 1'b0, "dis_pre");
        expect_at(D + 2, 8'h11, 1'b0, "dis_track");
        wait_neg(D + 4);

        // Poll mode: data follows db one cycle later, irq never rises.
        bus.ctrl = 8'h83;
        wait_neg(2);
        mark();
        bus.pins = 8'h3C;
        expect_at(D + 1, 8'h11, 1'b0, "poll_pre");
        expect_at(D + 2, 8'h3C, 1'b0, "poll_track");
        expect_at(D + 6, 8'h3C, 1'b0, "poll_noirq");
        wait_neg(D + 8);

        // Reset while pending discards everything.
        bus.ctrl = 8'h80;
        wait_neg(2);
        mark();
        bus.pins = 8'h55;
        expect_at(D + 2, 8'h55, 1'b1, "rst_pend_irq");
        wait_neg(D + 4);
        reset = 1'b0;
        mark();
        expect_at(0, 8'h00, 1'b0, "rst_pend_clr");
        expect_at(1, 8'h00, 1'b0, "rst_pend_clr2");
        bus.ctrl = 8'h00;
        bus.pins = 8'h00;
        wait_neg(3);
        reset = 1'b1;
        wait_neg(2);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            failures += sb.size();
            $display("FAIL drain: %0d checks still pending, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_port.md
# input_port

Debounced, interrupt-raising input peripheral: the source end of the CPU's `iport`/`pInt` interface, complementing the timer that consumes an `oport` and raises `pInt1`. It synchronizes and debounces 8 external pins, captures qualifying changes into a register presented on one CPU input port, and holds an interrupt line high until the CPU acknowledges through one of its output ports.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a pin change; legal range 1..255.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; while 0, all state is forced to reset values.
- `pins`  input  8  external asynchronous inputs (switches/buttons).
- `ctrl`  input  8  command byte, driven by a CPU `oport`. Bit 7 = enable, bit 6 = ack, bits 1:0 = mode. Other bits are ignored.
- `data`  output  8  captured value, wired to a CPU `iport`.
- `irq`  output  1  interrupt request, wired to a CPU `pIntN`.

## Operation
- **Synchronizer:** 2-flop chain `pins` → `s1` → `s2`.
- **Debounce:** registers `db` (accepted value, 8 bits), `cand` (8 bits) and `cnt` (8 bits).
  - If `s2 == db`: set `cnt=0`.
  - Else if `s2 != cand`: set `cand=s2` and `cnt=1`.
  - Else: increment `cnt`.
  - When `s2 == cand`, `s2 != db` and the count reaches `DEBOUNCE_CYCLES`: load `db=cand` and `cnt=0`. This update is the "accept" event.
  - Any change of `s2` mid-count restarts the count. A pulse shorter than `DEBOUNCE_CYCLES` cycles at `s2` never reaches `db`.
  - All 8 bits debounce as one word.
- **Event qualification** on accept, with old = `db` before the update and new = `cand`:
  - Mode 00: `old != new`.
  - Mode 01: any bit rises (`new & ~old`).
  - Mode 10: any bit falls (`~new & old`).
  - Mode 11: never qualifies (poll mode).
- **Ack detection:** `ack_q` holds `ctrl[6]` from the previous cycle. The ack pulse is `ctrl[6] & ~ack_q` (rising edge only; holding bit 6 high acks once).
- **Control state machine:** states IDLE, ARMED, PENDING.
  - IDLE (`ctrl[7]=0`): `data` tracks `db` (registered), `irq=0`. Go to ARMED when `ctrl[7]=1`.
  - ARMED: `data` tracks `db` if mode is 11; otherwise `data` holds. A qualifying accept loads `data=new`, sets `irq=1` and moves to PENDING.
  - PENDING: `data` and `irq=1` hold. Further accepts are dropped; `db` still updates.
    - An ack pulse clears `irq` and moves to ARMED.
    - An ack pulse and a qualifying accept in the same cycle: the new event wins. Load `data=new`, keep `irq=1`, stay PENDING.
  - Any state, `ctrl[7]=0`: go to IDLE next edge and clear `irq`. This overrides a simultaneous ack or accept.
  - Mode change while PENDING: `irq` stays until acked.

## Timing
- **Reset values:** `data=0x00`, `irq=0`, state IDLE.
  - Internal reset values: `s1=s2=db=cand=0`, `cnt=0`, `ack_q=0`.
  - Reset assertion mid-debounce or while PENDING discards everything immediately (asynchronous).
  - After release, the first state update occurs on the next rising `clk` edge.
- **Pin-change latency:**
  - Pins change before edge 0 and stay stable.
  - `s2` takes the new value at edge 1.
  - `db` updates at edge `1+DEBOUNCE_CYCLES`.
  - `data`/`irq` update at edge `2+DEBOUNCE_CYCLES`.
  - With default 4: `db` updates at edge 5, `irq` rises at edge 6.
- **Ack latency:** `ctrl[6]` rises before edge n → `irq=0` after edge n.
- **IDLE tracking:** `data` follows `db` with 1-cycle latency.
- **Outputs:** all are registered; there are no combinational paths from `pins` or `ctrl` to outputs.

## Test plan
- **Reset:** hold `reset=0` while toggling `pins`, then release → `data=0x00` and `irq=0`. With `ctrl=0x00` and `pins=0x00` stable, nothing changes for 20 cycles.
- **Basic capture:** `ctrl=0x80` (mode 00), `pins` 0x00 → 0x05 before edge 0 → `irq` rises at edge 6 with `data=0x05`. Then `ctrl=0xC0` for one cycle → `irq=0` next edge and `data` stays 0x05.
- **Glitch rejection:** `ctrl=0x80`, pins pulse to 0x01 for 3 cycles then back to 0x00 → `irq` stays 0 and `data` stays 0x00. A 4-cycle pulse → `irq=1` with `data=0x01`.
- **Edge modes:**
  - Mode 01 (`ctrl=0x81`): pins 0x01 → 0x00 gives no irq; 0x00 → 0x02 gives irq with `data=0x02`.
  - Mode 10 (`ctrl=0x82`): 0x02 → 0x00 gives irq with `data=0x00`.
- **Pending and simultaneous events:**
  - While PENDING with `data=0x05`, pins → 0x07 → `data` stays 0x05; `db=0x07`.
  - Ack landing on the same edge as a qualifying accept of 0x0F → `irq` stays 1 and `data=0x0F`.
- **Poll and disable:**
  - `ctrl=0x83`, pins → 0x3C → `data=0x3C` one cycle after `db` updates; `irq` never rises.
  - `ctrl=0x00` while PENDING → `irq=0` next edge; `data` then tracks `db`.
